decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 197 +++++++++++++++++++
 tb/tb_decode_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: register file, source operand selection with forwarding
// and writeback bypass, load-use hazard detection, and the registered
// decode outputs that feed the execute stage's ALU.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic        flush,
  input  logic        fwd_en,
  input  logic [2:0]  fwd_reg,
  input  logic [15:0] fwd_data,
  input  logic        ex_is_load,
  input  logic        wb_en,
  input  logic [2:0]  wb_reg,
  input  logic [15:0] wb_data,
  output logic        stall,
  output logic [2:0]  op,
  output logic [3:0]  alu_op,
  output logic [15:0] s_1,
  output logic [15:0] s_2,
  output logic [2:0]  rd,
  output logic [15:0] store_data,
  output logic        bubble
);

  localparam logic [2:0] OP_RRR    = 3'b000;
  localparam logic [2:0] OP_ADDI   = 3'b001;
  localparam logic [2:0] OP_ILLEGAL = 3'b010;
  localparam logic [2:0] OP_LUI    = 3'b011;
  localparam logic [2:0] OP_SW     = 3'b100;
  localparam logic [2:0] OP_LW     = 3'b101;
  localparam logic [2:0] OP_BRANCH = 3'b110;
  localparam logic [2:0] OP_JALR   = 3'b111;

  logic [15:0] regs [8];

  logic [2:0]  dec_op;
  logic [2:0]  f_ra;
  logic [2:0]  f_rb;
  logic [2:0]  f_rc;
  logic [3:0]  f_alu;
  logic [15:0] sext7;
  logic [15:0] lui_val;

  assign dec_op  = instr[15:13];
  assign f_ra    = instr[12:10];
  assign f_rb    = instr[9:7];
  assign f_alu   = instr[6:3];
  assign f_rc    = instr[2:0];
  assign sext7   = {{9{instr[6]}}, instr[6:0]};
  assign lui_val = {instr[9:0], 6'b0};

  // Operand source selection: execute-stage forward beats the writeback
  // bypass, which beats the array. R0 is hard-wired to zero. A load in
  // execute has no data yet, so it is never forwarded.
  function automatic logic [15:0] pick_src(
    input logic [2:0]  idx,
    input logic [15:0] arr,
    input logic        f_en,
    input logic [2:0]  f_reg,
    input logic [15:0] f_data,
    input logic        f_load,
    input logic        w_en,
    input logic [2:0]  w_reg,
    input logic [15:0] w_data
  );
    if (idx == 3'd0)
      return 16'h0000;
    else if (f_en && (f_reg == idx) && !f_load)
      return f_data;
    else if (w_en && (w_reg == idx))
      return w_data;
    else
      return arr;
  endfunction

  logic [15:0] val_a;
  logic [15:0] val_b;
  logic [15:0] val_c;

  assign val_a = pick_src(f_ra, regs[f_ra], fwd_en, fwd_reg, fwd_data, ex_is_load, wb_en, wb_reg, wb_data);
  assign val_b = pick_src(f_rb, regs[f_rb], fwd_en, fwd_reg, fwd_data, ex_is_load, wb_en, wb_reg, wb_data);
  assign val_c = pick_src(f_rc, regs[f_rc], fwd_en, fwd_reg, fwd_data, ex_is_load, wb_en, wb_reg, wb_data);

  // Register file write port; reset clears everything and outranks wb.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else if (wb_en && (wb_reg != 3'd0)) begin
      regs[wb_reg] <= wb_data;
    end
  end

  logic use_a;
  logic use_b;
  logic use_c;

  // Which register fields the current opcode actually reads.
  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    use_c = 1'b0;
    case (dec_op)
      OP_RRR:                   begin use_b = 1'b1; use_c = 1'b1; end
      OP_ADDI, OP_LW, OP_JALR:  use_b = 1'b1;
      OP_SW, OP_BRANCH:         begin use_a = 1'b1; use_b = 1'b1; end
      default:                  ;
    endcase
  end

  logic hazard;

  assign hazard = ex_is_load && fwd_en && (fwd_reg != 3'd0) &&
                  ((use_a && (f_ra == fwd_reg)) ||
                   (use_b && (f_rb == fwd_reg)) ||
                   (use_c && (f_rc == fwd_reg)));

  // A flush squashes the instruction anyway, so it suppresses the stall.
  assign stall = !reset && instr_valid && !flush && hazard;

  logic        nxt_bubble;
  logic [2:0]  nxt_op;
  logic [3:0]  nxt_alu;
  logic [15:0] nxt_s1;
  logic [15:0] nxt_s2;
  logic [2:0]  nxt_rd;
  logic [15:0] nxt_sd;

  // Decode mapping; anything not issued becomes an all-zero bubble.
  always_comb begin
    nxt_bubble = 1'b1;
    nxt_op     = 3'd0;
    nxt_alu    = 4'd0;
    nxt_s1     = 16'h0000;
    nxt_s2     = 16'h0000;
    nxt_rd     = 3'd0;
    nxt_sd     = 16'h0000;
    if (instr_valid && !stall && !flush && (dec_op != OP_ILLEGAL)) begin
      nxt_bubble = 1'b0;
      nxt_op     = dec_op;
      case (dec_op)
        OP_RRR: begin
          nxt_s1  = val_b;
          nxt_s2  = val_c;
          nxt_alu = f_alu;
          nxt_rd  = f_ra;
        end
        OP_ADDI, OP_LW: begin
          nxt_s1 = val_b;
          nxt_s2 = sext7;
          nxt_rd = f_ra;
        end
        OP_LUI: begin
          nxt_s1 = lui_val;
          nxt_rd = f_ra;
        end
        OP_SW: begin
          nxt_s1 = val_b;
          nxt_s2 = sext7;
          nxt_sd = val_a;
        end
        OP_BRANCH: begin
          nxt_s1 = val_a;
          nxt_s2 = val_b;
        end
        OP_JALR: begin
          nxt_s1 = val_b;
          nxt_rd = f_ra;
        end
        default: ;
      endcase
    end
  end

  // Pipeline register between decode and execute.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble     <= 1'b1;
      op         <= 3'd0;
      alu_op     <= 4'd0;
      s_1        <= 16'h0000;
      s_2        <= 16'h0000;
      rd         <= 3'd0;
      store_data <= 16'h0000;
    end else begin
      bubble     <= nxt_bubble;
      op         <= nxt_op;
      alu_op     <= nxt_alu;
      s_1        <= nxt_s1;
      s_2        <= nxt_s2;
      rd         <= nxt_rd;
      store_data <= nxt_sd;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a driver computes the expected
// registered outputs from a behavioural model and queues them; a monitor
// pops one entry after each clock edge and compares.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        flush;
  logic        fwd_en;
  logic [2:0]  fwd_reg;
  logic [15:0] fwd_data;
  logic        ex_is_load;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        stall;
  logic [2:0]  op;
  logic [3:0]  alu_op;
  logic [15:0] s_1;
  logic [15:0] s_2;
  logic [2:0]  rd;
  logic [15:0] store_data;
  logic        bubble;

  decode_stage dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .flush(flush), .fwd_en(fwd_en), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .ex_is_load(ex_is_load), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .stall(stall), .op(op), .alu_op(alu_op), .s_1(s_1), .s_2(s_2), .rd(rd),
    .store_data(store_data), .bubble(bubble)
  );

  typedef struct {
    logic        bubble;
    logic [2:0]  op;
    logic [3:0]  alu_op;
    logic [15:0] s_1;
    logic [15:0] s_2;
    logic [2:0]  rd;
    logic [15:0] store_data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_rf [8];
  int          checks = 0;
  int          errors = 0;
  int          out_idx = 0;
  logic        last_stall;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model of a register read as the architecture defines it.
  function automatic logic [15:0] model_read(input logic [2:0] idx);
    if (idx == 3'd0) return 16'h0000;
    if (fwd_en && fwd_reg == idx && !ex_is_load) return fwd_data;
    if (wb_en && wb_reg == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic logic [15:0] enc_rrr(input logic [2:0] a, b, c, input logic [3:0] f);
    return {3'b000, a, b, f, c};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] o, a, b, input logic [6:0] imm);
    return {o, a, b, imm};
  endfunction

  // Drive one cycle of inputs, predict stall and the next outputs, then
  // advance the architectural register model past this edge.
  task automatic drive_cycle(
    input logic rst, v, input logic [15:0] ins, input logic fl,
    input logic fe, input logic [2:0] fr, input logic [15:0] fd, input logic ld,
    input logic we, input logic [2:0] wr, input logic [15:0] wd);
    exp_t        e;
    logic [2:0]  o, ra, rb, rc;
    logic [2:0]  srcs[$];
    logic        hz;
    reset = rst; instr_valid = v; instr = ins; flush = fl;
    fwd_en = fe; fwd_reg = fr; fwd_data = fd; ex_is_load = ld;
    wb_en = we; wb_reg = wr; wb_data = wd;
    o = ins[15:13]; ra = ins[12:10]; rb = ins[9:7]; rc = ins[2:0];
    case (o)
      3'b000:                 srcs = '{rb, rc};
      3'b001, 3'b101, 3'b111: srcs = '{rb};
      3'b100, 3'b110:         srcs = '{ra, rb};
      default:                srcs = {};
    endcase
    hz = 1'b0;
    foreach (srcs[k])
      if (!rst && v && !fl && ld && fe && fr != 3'd0 && srcs[k] == fr) hz = 1'b1;
    e = '{1'b1, 3'd0, 4'd0, 16'h0, 16'h0, 3'd0, 16'h0};
    if (!rst && v && !hz && !fl && o != 3'b010) begin
      e.bubble = 1'b0;
      e.op = o;
      case (o)
        3'b000: begin e.s_1 = model_read(rb); e.s_2 = model_read(rc); e.alu_op = ins[6:3]; e.rd = ra; end
        3'b001, 3'b101: begin e.s_1 = model_read(rb); e.s_2 = 16'($signed(ins[6:0])); e.rd = ra; end
        3'b011: begin e.s_1 = ins[9:0] * 16'd64; e.rd = ra; end
        3'b100: begin e.s_1 = model_read(rb); e.s_2 = 16'($signed(ins[6:0])); e.store_data = model_read(ra); end
        3'b110: begin e.s_1 = model_read(ra); e.s_2 = model_read(rb); end
        default: begin e.s_1 = model_read(rb); e.rd = ra; end
      endcase
    end
    #1;
    checks++;
    if (stall !== hz) begin
      errors++;
      $display("[TB] FAIL stall at t=%0t: got %b expected %b", $time, stall, hz);
    end
    last_stall = hz;
    exp_q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    end else if (we && wr != 3'd0) begin
      m_rf[wr] = wd;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive_cycle(0, 0, 16'h0, 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
  endtask

  // Monitor: one registered output per edge, compared against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bubble !== e.bubble || op !== e.op || alu_op !== e.alu_op ||
            s_1 !== e.s_1 || s_2 !== e.s_2 || rd !== e.rd || store_data !== e.store_data) begin
          errors++;
          $display("[TB] FAIL out#%0d: got b=%b op=%h alu=%h s1=%h s2=%h rd=%h sd=%h expected b=%b op=%h alu=%h s1=%h s2=%h rd=%h sd=%h",
                   out_idx, bubble, op, alu_op, s_1, s_2, rd, store_data,
                   e.bubble, e.op, e.alu_op, e.s_1, e.s_2, e.rd, e.store_data);
        end
        out_idx++;
      end
    end
  end

  // Directed scenarios followed by a randomized stream.
  initial begin
    logic [15:0] ins;
    logic        v, fl, fe, ld, we, rst;
    logic [2:0]  fr, wr;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    last_stall = 1'b0;

    drive_cycle(1, 0, 16'h0, 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    drive_cycle(1, 1, enc_rrr(3'd1, 3'd2, 3'd3, 4'd1), 0, 0, 3'd0, 16'h0, 0, 1, 3'd4, 16'h5555);

    // add R1,R2,R3 after R2 is written
    drive_cycle(0, 0, 16'h0, 0, 0, 3'd0, 16'h0, 0, 1, 3'd2, 16'h1234);
    drive_cycle(0, 1, enc_rrr(3'd1, 3'd2, 3'd3, 4'd1), 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);

    // forward beats writeback
    drive_cycle(0, 1, enc_i(3'b001, 3'd4, 3'd2, 7'h7F), 0, 1, 3'd2, 16'hBEEF, 0, 1, 3'd2, 16'h1111);

    // load-use stall, then writeback bypass on the retry
    drive_cycle(0, 1, enc_i(3'b100, 3'd5, 3'd6, 7'd3), 0, 1, 3'd5, 16'h0, 1, 0, 3'd0, 16'h0);
    drive_cycle(0, 1, enc_i(3'b100, 3'd5, 3'd6, 7'd3), 0, 0, 3'd0, 16'h0, 0, 1, 3'd5, 16'h00AA);

    // same hazard with flush
    drive_cycle(0, 1, enc_i(3'b100, 3'd5, 3'd6, 7'd3), 1, 1, 3'd5, 16'h0, 1, 0, 3'd0, 16'h0);

    // lui, illegal opcode, R0 writes and reads
    drive_cycle(0, 1, {3'b011, 3'd7, 10'h3FF}, 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    drive_cycle(0, 1, 16'h5A5A, 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    drive_cycle(0, 1, enc_rrr(3'd1, 3'd0, 3'd0, 4'd3), 0, 1, 3'd0, 16'h7777, 0, 1, 3'd0, 16'hFFFF);
    drive_cycle(0, 1, enc_rrr(3'd1, 3'd0, 3'd0, 4'd3), 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);

    // branch and jalr reads
    drive_cycle(0, 1, enc_i(3'b110, 3'd2, 3'd5, 7'h11), 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    drive_cycle(0, 1, enc_i(3'b111, 3'd6, 3'd2, 7'h22), 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);

    // fill registers, then reset mid-stream with a pending write
    for (int i = 1; i < 8; i++)
      drive_cycle(0, 0, 16'h0, 0, 0, 3'd0, 16'h0, 0, 1, 3'(i), 16'(16'h0100 * i + 16'h0011));
    drive_cycle(1, 1, enc_rrr(3'd1, 3'd2, 3'd3, 4'd2), 0, 0, 3'd0, 16'h0, 0, 1, 3'd3, 16'hABCD);
    for (int i = 1; i < 8; i++)
      drive_cycle(0, 1, enc_rrr(3'd1, 3'(i), 3'(i), 4'd5), 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);

    // randomized stream; upstream holds the instruction after a stall
    ins = 16'h0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) ins = 16'($urandom);
      v   = ($urandom_range(0, 99) < 85) || last_stall;
      fl  = ($urandom_range(0, 99) < 8);
      fe  = $urandom_range(0, 1);
      fr  = 3'($urandom);
      ld  = fe && !last_stall && ($urandom_range(0, 99) < 35);
      we  = ($urandom_range(0, 99) < 60);
      wr  = 3'($urandom);
      rst = ($urandom_range(0, 99) < 2);
      drive_cycle(rst, v, ins, fl, fe, fr, 16'($urandom), ld, we, wr, 16'($urandom));
    end
    idle_cycle();

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending outputs expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
